// File: rtl/mux4x1_rr_sched.sv
// Four-lane byte buffer with a round-robin drain onto one registered output lane.
// Each lane has a small FIFO and status flags. The arbiter pops at most one head byte per clock.
module mux4x1_rr_sched #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4,
    parameter int AF_THRESH = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in0,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    input  logic [DATA_W-1:0] in3,
    input  logic [3:0]        valid,
    input  logic              pause,
    output logic [DATA_W-1:0] out,
    output logic              valid_out,
    output logic [1:0]        sel,
    output logic [3:0]        empty,
    output logic [3:0]        full,
    output logic [3:0]        almost_full,
    output logic [3:0]        overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_C    = (AW+1)'(AF_THRESH);
    localparam logic [AW:0] ONE_C   = (AW+1)'(1);

    logic [DATA_W-1:0] lane_data [4];
    logic [DATA_W-1:0] head      [4];

    logic              grant_valid;
    logic [1:0]        grant_lane;
    logic [1:0]        ptr_reg;
    logic [DATA_W-1:0] out_reg;
    logic [1:0]        sel_reg;
    logic              valid_out_reg;

    assign lane_data[0] = in0;
    assign lane_data[1] = in1;
    assign lane_data[2] = in2;
    assign lane_data[3] = in3;

    // Per-lane FIFO: full is taken from the pre-edge count, so a push into a
    // full lane is dropped even if the same lane is popped this cycle.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [DATA_W-1:0] mem [DEPTH];
        logic [AW-1:0]     wr_ptr_reg;
        logic [AW-1:0]     rd_ptr_reg;
        logic [AW:0]       count_reg;
        logic [AW:0]       count_next;
        logic              overflow_reg;
        logic              push;
        logic              pop;

        assign push = valid[gi] && !full[gi];
        assign pop  = grant_valid && (grant_lane == 2'(gi));

        always_comb begin
            count_next = count_reg;
            case ({push, pop})
                2'b10:   count_next = count_reg + ONE_C;
                2'b01:   count_next = count_reg - ONE_C;
                default: count_next = count_reg;
            endcase
        end

        always_ff @(posedge clk) begin
            if (push) begin
                mem[wr_ptr_reg] <= lane_data[gi];
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                wr_ptr_reg   <= '0;
                rd_ptr_reg   <= '0;
                count_reg    <= '0;
                overflow_reg <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + AW'(1);
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + AW'(1);
                end
                count_reg <= count_next;
                if (valid[gi] && full[gi]) begin
                    overflow_reg <= 1'b1;
                end
            end
        end

        assign head[gi]        = mem[rd_ptr_reg];
        assign empty[gi]       = (count_reg == '0);
        assign full[gi]        = (count_reg == DEPTH_C);
        assign almost_full[gi] = (count_reg >= AF_C);
        assign overflow[gi]    = overflow_reg;
    end

    // Search ptr, ptr+1, ptr+2, ptr+3 (mod 4); the first non-empty lane wins.
    always_comb begin
        logic       found;
        logic [1:0] cand;
        found      = 1'b0;
        cand       = ptr_reg;
        grant_lane = ptr_reg;
        for (int k = 0; k < 4; k++) begin
            cand = ptr_reg + 2'(k);
            if (!found && !empty[cand]) begin
                found      = 1'b1;
                grant_lane = cand;
            end
        end
        grant_valid = found && !pause;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_reg       <= '0;
            sel_reg       <= '0;
            valid_out_reg <= 1'b0;
            ptr_reg       <= '0;
        end else if (grant_valid) begin
            out_reg       <= head[grant_lane];
            sel_reg       <= grant_lane;
            valid_out_reg <= 1'b1;
            ptr_reg       <= grant_lane + 2'd1;
        end else begin
            valid_out_reg <= 1'b0;
        end
    end

    assign out       = out_reg;
    assign sel       = sel_reg;
    assign valid_out = valid_out_reg;

endmodule
